// File: rtl/bin2bcd_stream.sv
// Pipelined binary-to-BCD converter (double-dabble) with a valid/ready stream on each side.
// Each stage handles a slice of the input bits. Stalled stages hold their contents, and bubbles between stages are collapsed.
module bin2bcd_stream #(
    parameter int BIN_WIDTH  = 64,
    parameter int BCD_DIGITS = 20,
    parameter int STAGES     = 4,
    parameter int SIGNED_EN  = 0
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    input  logic [BIN_WIDTH-1:0]                 i_bin,
    input  logic                                 i_signed,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic [4*BCD_DIGITS-1:0]              o_bcd,
    output logic                                 o_neg,
    output logic [$clog2(BCD_DIGITS+1)-1:0]      o_ndigits
);

    localparam int STEPS      = (STAGES > 0) ? (BIN_WIDTH / STAGES) : 1;
    localparam int W          = 4*BCD_DIGITS + BIN_WIDTH;
    localparam int NDW        = $clog2(BCD_DIGITS+1);
    // ceil(BIN_WIDTH * log10(2)) in integer arithmetic
    localparam int MIN_DIGITS = (BIN_WIDTH*30103 + 99999) / 100000;
    localparam logic [BIN_WIDTH-1:0] ONE = {{(BIN_WIDTH-1){1'b0}}, 1'b1};

    if (STAGES < 1) begin : g_chk_stages
        $fatal(1, "bin2bcd_stream: STAGES must be at least 1");
    end else if (BIN_WIDTH % STAGES != 0) begin : g_chk_div
        $fatal(1, "bin2bcd_stream: BIN_WIDTH must be a multiple of STAGES");
    end
    if (BCD_DIGITS < MIN_DIGITS) begin : g_chk_digits
        $fatal(1, "bin2bcd_stream: BCD_DIGITS too small for BIN_WIDTH");
    end

    // The working vector is {bcd, remaining binary}. Each step corrects the digits, then shifts the whole vector left by one bit.
    function automatic logic [W-1:0] dd_steps(input logic [W-1:0] v_in);
        logic [W-1:0] v;
        logic [3:0]   dig;
        v = v_in;
        for (int s = 0; s < STEPS; s++) begin
            for (int d = 0; d < BCD_DIGITS; d++) begin
                dig = v[BIN_WIDTH + 4*d +: 4];
                if (dig > 4'd4) begin
                    v[BIN_WIDTH + 4*d +: 4] = dig + 4'd3;
                end
            end
            v = {v[W-2:0], 1'b0};
        end
        return v;
    endfunction

    logic [W-1:0]           vec_q [STAGES];
    logic [W-1:0]           vec_d [STAGES];
    logic [STAGES-1:0]      valid_q, valid_d;
    logic [STAGES-1:0]      neg_q, neg_d;
    logic [STAGES-1:0]      load_s;
    logic                   full_s;
    logic                   in_neg_s;
    logic [BIN_WIDTH-1:0]   mag_s;
    logic [NDW-1:0]         ndig_s;

    // Stage k can load if i_ready is high, or if some stage at or below k is empty.
    always_comb begin
        full_s = 1'b1;
        load_s = {STAGES{1'b0}};
        for (int k = STAGES-1; k >= 0; k--) begin
            full_s    = full_s & valid_q[k];
            load_s[k] = i_ready | ~full_s;
        end
    end

    // Take the magnitude of a negative signed input. The most negative value wraps to 2^(BIN_WIDTH-1), which is the correct magnitude.
    always_comb begin
        in_neg_s = (SIGNED_EN != 0) && i_signed && i_bin[BIN_WIDTH-1];
        if (in_neg_s) begin
            mag_s = ~i_bin + ONE;
        end else begin
            mag_s = i_bin;
        end
    end

    // Next state of each stage: load new contents from upstream, or hold.
    always_comb begin
        valid_d = valid_q;
        neg_d   = neg_q;
        for (int k = 0; k < STAGES; k++) begin
            vec_d[k] = vec_q[k];
        end
        if (load_s[0]) begin
            valid_d[0] = i_valid;
            neg_d[0]   = in_neg_s;
            vec_d[0]   = dd_steps({{(4*BCD_DIGITS){1'b0}}, mag_s});
        end else begin
            valid_d[0] = valid_q[0];
        end
        for (int k = 1; k < STAGES; k++) begin
            if (load_s[k]) begin
                valid_d[k] = valid_q[k-1];
                neg_d[k]   = neg_q[k-1];
                vec_d[k]   = dd_steps(vec_q[k-1]);
            end else begin
                valid_d[k] = valid_q[k];
            end
        end
    end

    // Pipeline registers. A synchronous reset clears every stage, so a request presented during reset is dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= {STAGES{1'b0}};
            neg_q   <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                vec_q[k] <= {W{1'b0}};
            end
        end else begin
            valid_q <= valid_d;
            neg_q   <= neg_d;
            for (int k = 0; k < STAGES; k++) begin
                vec_q[k] <= vec_d[k];
            end
        end
    end

    // Significant digit count: index of the highest nonzero digit plus one, never less than 1.
    always_comb begin
        ndig_s = {{(NDW-1){1'b0}}, 1'b1};
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (o_bcd[4*d +: 4] != 4'd0) begin
                ndig_s = NDW'(d + 1);
            end else begin
                ndig_s = ndig_s;
            end
        end
    end

    assign o_ready   = load_s[0];
    assign o_valid   = valid_q[STAGES-1];
    assign o_neg     = neg_q[STAGES-1];
    assign o_bcd     = vec_q[STAGES-1][W-1:BIN_WIDTH];
    assign o_ndigits = ndig_s;

endmodule
